sys_cmd_decoder: RTL and testbench

- Receive-side command decoder directly downstream of the bus synchronizer on the UART RX path.
- Consumes synchronized bytes (sync_bus plus a one-cycle enable_pulse) and assembles command frames.
- Issues register-file write/read strobes and ALU operation requests.
- Aborts incomplete frames after a programmable inactivity timeout.

---
 rtl/sys_cmd_decoder.sv | 166 ++++++++++++++++
 tb/tb_sys_cmd_decoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sys_cmd_decoder.sv
// Receive-side command decoder: assembles UART command frames into register-file
// write/read strobes and ALU requests, aborting stalled frames after a timeout.
//
// state   | meaning
// IDLE    | waiting for a command byte
// WR_ADDR | write frame, expecting address byte
// WR_DATA | write frame, expecting data byte
// RD_ADDR | read frame, expecting address byte
// OP_A    | ALU frame, expecting operand A (written to reg 0)
// OP_B    | ALU frame, expecting operand B (written to reg 1)
// ALU_FUN | expecting ALU function code
module sys_cmd_decoder #(
  parameter int BUS_WIDTH      = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  rx_data,
  input  logic                  rx_valid,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [BUS_WIDTH-1:0]  rf_wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [BUS_WIDTH-1:0] CMD_WR     = BUS_WIDTH'(8'hAA);
  localparam logic [BUS_WIDTH-1:0] CMD_RD     = BUS_WIDTH'(8'hBB);
  localparam logic [BUS_WIDTH-1:0] CMD_ALU_OP = BUS_WIDTH'(8'hCC);
  localparam logic [BUS_WIDTH-1:0] CMD_ALU    = BUS_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OP_A,
    OP_B,
    ALU_FUN
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [BUS_WIDTH-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_en_d     = 1'b0;
    alu_fun_d    = alu_fun_q;
    frame_err_d  = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (rx_valid) begin
        unique case (rx_data)
          CMD_WR:     state_d = WR_ADDR;
          CMD_RD:     state_d = RD_ADDR;
          CMD_ALU_OP: state_d = OP_A;
          CMD_ALU:    state_d = ALU_FUN;
          default:    state_d = IDLE;
        endcase
      end
    end else if (rx_valid) begin
      // A byte on the terminal-count cycle still lands here and beats the timeout.
      cnt_d = '0;
      unique case (state_q)
        WR_ADDR: begin
          rf_addr_d = rx_data[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
        WR_DATA: begin
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
        RD_ADDR: begin
          rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = IDLE;
        end
        OP_A: begin
          rf_addr_d    = '0;
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = OP_B;
        end
        OP_B: begin
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = ALU_FUN;
        end
        ALU_FUN: begin
          alu_fun_d = rx_data[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (cnt_q == CNT_LAST) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign alu_en     = alu_en_q;
  assign alu_fun    = alu_fun_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Directed bench for sys_cmd_decoder: table of single-cycle vectors plus
// hand-written timeout, boundary and reset sequences.
module tb_sys_cmd_decoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rf_wr_en, rf_rd_en, alu_en, frame_err, busy;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  sys_cmd_decoder #(
    .BUS_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Packed output image: {wr, rd, addr, wdata, alu_en, fun, ferr, busy}
  function automatic logic [20:0] mk(input logic wr, input logic rd, input logic [3:0] addr,
                                     input logic [7:0] wd, input logic ae, input logic [3:0] fun,
                                     input logic fe, input logic bz);
    return {wr, rd, addr, wd, ae, fun, fe, bz};
  endfunction

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, frame_err, busy};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got wr=%b rd=%b addr=%h wd=%h alu=%b fun=%h ferr=%b busy=%b, expected wr=%b rd=%b addr=%h wd=%h alu=%b fun=%h ferr=%b busy=%b",
                  name, act[20], act[19], act[18:15], act[14:7], act[6], act[5:2], act[1], act[0],
                  exp[20], exp[19], exp[18:15], exp[14:7], exp[6], exp[5:2], exp[1], exp[0]);
  endtask

  initial begin
    //                 v     d       wr  rd  addr  wdata  alu fun  fe  busy
    vecs[0]  = '{1'b1, 8'hAA, mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 1)};
    vecs[1]  = '{1'b1, 8'h05, mk(0, 0, 4'h5, 8'h00, 0, 4'h0, 0, 1)};
    vecs[2]  = '{1'b1, 8'h3C, mk(1, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0)};
    vecs[3]  = '{1'b0, 8'h00, mk(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0)};
    vecs[4]  = '{1'b1, 8'hBB, mk(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 1)};
    vecs[5]  = '{1'b1, 8'hF2, mk(0, 1, 4'h2, 8'h3C, 0, 4'h0, 0, 0)};
    vecs[6]  = '{1'b1, 8'hCC, mk(0, 0, 4'h2, 8'h3C, 0, 4'h0, 0, 1)};
    vecs[7]  = '{1'b1, 8'h10, mk(1, 0, 4'h0, 8'h10, 0, 4'h0, 0, 1)};
    vecs[8]  = '{1'b1, 8'h20, mk(1, 0, 4'h1, 8'h20, 0, 4'h0, 0, 1)};
    vecs[9]  = '{1'b1, 8'h03, mk(0, 0, 4'h1, 8'h20, 1, 4'h3, 0, 0)};
    vecs[10] = '{1'b1, 8'h7E, mk(0, 0, 4'h1, 8'h20, 0, 4'h3, 0, 0)};
    vecs[11] = '{1'b1, 8'hDD, mk(0, 0, 4'h1, 8'h20, 0, 4'h3, 0, 1)};
    vecs[12] = '{1'b1, 8'h0A, mk(0, 0, 4'h1, 8'h20, 1, 4'hA, 0, 0)};
    vecs[13] = '{1'b1, 8'hAA, mk(0, 0, 4'h1, 8'h20, 0, 4'hA, 0, 1)};
    vecs[14] = '{1'b1, 8'hAA, mk(0, 0, 4'hA, 8'h20, 0, 4'hA, 0, 1)};
    vecs[15] = '{1'b1, 8'hBB, mk(1, 0, 4'hA, 8'hBB, 0, 4'hA, 0, 0)};
    vecs[16] = '{1'b0, 8'hAA, mk(0, 0, 4'hA, 8'hBB, 0, 4'hA, 0, 0)};

    step(1'b0, 1'b0, 8'h00);
    chk("reset", mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));

    for (int i = 0; i < 17; i++) begin
      step(1'b1, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Timeout: write frame stalls in WR_DATA (addr=1, wdata stays 0xBB, fun 0xA).
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'h01);
    chk("to_start", mk(0, 0, 4'h1, 8'hBB, 0, 4'hA, 0, 1));
    for (int k = 1; k <= TO + 1; k++) begin
      step(1'b1, 1'b0, 8'h00);
      if (k == TO - 1 || k == TO || k == TO + 1)
        chk($sformatf("to_idle%0d", k),
            mk(0, 0, 4'h1, 8'hBB, 0, 4'hA, (k == TO), (k < TO)));
    end
    step(1'b1, 1'b1, 8'hBB);
    step(1'b1, 1'b1, 8'h01);
    chk("rd_after_to", mk(0, 1, 4'h1, 8'hBB, 0, 4'hA, 0, 0));

    // Boundary: data byte arrives on the terminal-count cycle and wins.
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'h02);
    for (int k = 1; k < TO; k++) step(1'b1, 1'b0, 8'h00);
    chk("bnd_pre", mk(0, 0, 4'h2, 8'hBB, 0, 4'hA, 0, 1));
    step(1'b1, 1'b1, 8'h55);
    chk("bnd_byte", mk(1, 0, 4'h2, 8'h55, 0, 4'hA, 0, 0));
    step(1'b1, 1'b0, 8'h00);
    chk("bnd_after", mk(0, 0, 4'h2, 8'h55, 0, 4'hA, 0, 0));

    // Reset in WR_DATA, then the stray data byte must not act as a command.
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'h07);
    chk("rst_pre", mk(0, 0, 4'h7, 8'h55, 0, 4'hA, 0, 1));
    step(1'b0, 1'b0, 8'h00);
    chk("rst_mid", mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    step(1'b1, 1'b1, 8'h3C);
    chk("rst_junk", mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    step(1'b1, 1'b0, 8'h00);
    chk("rst_quiet", mk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    step(1'b1, 1'b1, 8'hDD);
    step(1'b1, 1'b1, 8'h0F);
    chk("rst_recover", mk(0, 0, 4'h0, 8'h00, 1, 4'hF, 0, 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
